drum_mac_pipe: RTL and testbench

- Pipelined, parametrised signed DRUM approximate multiply-accumulate unit.
- Adds a valid/ready stream interface, a 3-stage pipeline, a per-beat exact/approximate mode select and a running accumulator.
- Sits between a streaming operand source and a result sink; the tile top wires it to ui_in/uo_out through a small I/O adapter.

---
 rtl/drum_mac_if.sv | 29 ++
 rtl/drum_mac_pipe.sv | 154 +++++++++++++++
 tb/tb_drum_mac_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/drum_mac_if.sv
// Stream bundle for drum_mac_pipe: operand beats in, product/accumulator beats out.
// master drives operands and out_ready; slave is the MAC unit.
interface drum_mac_if #(
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int ACC_W = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [M-1:0]     in_b;
    logic             in_exact;
    logic             in_clr;
    logic             out_valid;
    logic             out_ready;
    logic [N+M-1:0]   out_prod;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_exact, in_clr, out_ready,
        input  in_ready, out_valid, out_prod, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_exact, in_clr, out_ready,
        output in_ready, out_valid, out_prod, out_acc, out_ovf
    );
endinterface

// File: rtl/drum_mac_pipe.sv
// Three-stage signed DRUM approximate multiply-accumulate with valid/ready streams.
// Define DRUM_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module drum_mac_pipe #(
    parameter int K     = 6,
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int ACC_W = 20
) (
    input  logic      clk,
    input  logic      rst,
    drum_mac_if.slave bus
);
    localparam int W  = (N > M) ? N : M;
    localparam int LW = $clog2(W);
    localparam int SW = LW + 1;
    localparam int PW = N + M;

    function automatic logic [LW-1:0] lead_one(input logic [W-1:0] v);
        lead_one = '0;
        for (int i = 0; i < W; i++)
            if (v[i]) lead_one = LW'(i);
    endfunction

    // Keep the K-1 bits starting at the leading one and force the next bit to 1,
    // which centres the truncation error and keeps the approximation unbiased.
    function automatic logic [K-1:0] seg_of(input logic [W-1:0] mag, input logic [LW-1:0] l);
        logic [W-1:0] sh;
        sh = mag >> ((int'(l) > K - 1) ? (int'(l) - K + 1) : 0);
        if (int'(l) <= K - 1) seg_of = mag[K-1:0];
        else                  seg_of = sh[K-1:0] | K'(1) | (K'(1) << (K - 1));
    endfunction

    function automatic logic [SW-1:0] shift_of(input logic [LW-1:0] l);
        shift_of = (int'(l) > K - 1) ? SW'(int'(l) - K + 1) : '0;
    endfunction

    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // S1: sign, magnitudes, leading-one positions
    logic [W-1:0]  mag_a, mag_b;
    logic          s1_valid, s1_sign, s1_exact, s1_clr;
    logic [W-1:0]  s1_mag_a, s1_mag_b;
    logic [LW-1:0] s1_la, s1_lb;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mag_a = '0;
        mag_b = '0;
        mag_a[N-1:0] = bus.in_a[N-1] ? (~bus.in_a + N'(1)) : bus.in_a;
        mag_b[M-1:0] = bus.in_b[M-1] ? (~bus.in_b + M'(1)) : bus.in_b;
    end

    // NOTE: sequential state uses non-blocking assignments so all stages sample
    // the pre-edge values of their predecessors.
    // NOTE: the datapath registers are few and small, so they are reset along with
    // the valid bits; this keeps out_prod/out_acc at zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exact <= 1'b0;
            s1_clr   <= 1'b0;
            s1_mag_a <= '0;
            s1_mag_b <= '0;
            s1_la    <= '0;
            s1_lb    <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign  <= bus.in_a[N-1] ^ bus.in_b[M-1];
                s1_exact <= bus.in_exact;
                s1_clr   <= bus.in_clr;
                s1_mag_a <= mag_a;
                s1_mag_b <= mag_b;
                s1_la    <= lead_one(mag_a);
                s1_lb    <= lead_one(mag_b);
            end
        end
    end

    // S2: exact or DRUM magnitude product
    logic [K-1:0]  seg_a, seg_b;
    logic [SW-1:0] sh_a, sh_b;
    logic [PW-1:0] p_approx, p_exact;
    logic          s2_valid, s2_sign, s2_clr;
    logic [PW-1:0] s2_p;

    always_comb begin
        seg_a    = seg_of(s1_mag_a, s1_la);
        seg_b    = seg_of(s1_mag_b, s1_lb);
        sh_a     = shift_of(s1_la);
        sh_b     = shift_of(s1_lb);
        p_approx = (PW'(seg_a) * PW'(seg_b)) << (sh_a + sh_b);
        p_exact  = PW'(s1_mag_a) * PW'(s1_mag_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_clr   <= 1'b0;
            s2_p     <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_clr  <= s1_clr;
                s2_p    <= s1_exact ? p_exact : p_approx;
            end
        end
    end

    // S3: apply sign, accumulate, track sticky overflow
    logic [PW-1:0]    p_signed;
    logic [ACC_W-1:0] ext, sum, acc_next;
    logic             add_ovf, ovf_next;

    always_comb begin
        p_signed = s2_sign ? (~s2_p + PW'(1)) : s2_p;
        ext      = ACC_W'($signed(p_signed));
        sum      = bus.out_acc + ext;
        add_ovf  = (bus.out_acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != ext[ACC_W-1]);
        acc_next = sum;
        ovf_next = bus.out_ovf | add_ovf;
        if (s2_clr) begin
            acc_next = ext;
            ovf_next = 1'b0;
        end
`ifdef DRUM_ACC_SAT_EN
        else if (add_ovf) begin
            // Both addends share a sign on overflow, so ext gives the true direction.
            acc_next = ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_prod  <= '0;
            bus.out_acc   <= '0;
            bus.out_ovf   <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= s2_valid;
            if (s2_valid) begin
                bus.out_prod <= p_signed;
                bus.out_acc  <= acc_next;
                bus.out_ovf  <= ovf_next;
            end
        end
    end
endmodule

// File: tb/tb_drum_mac_pipe.sv
// Self-checking bench for drum_mac_pipe: arithmetic model plus scoreboard queue,
// with hand-computed expectations on directed beats.
module tb_drum_mac_pipe;
    localparam int K = 6, N = 8, M = 8, ACC_W = 20;
    localparam longint AMAX = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint AMIN = -AMAX - 1;
`ifdef DRUM_ACC_SAT_EN
    localparam int OVF_ACC = 524287;
`else
    localparam int OVF_ACC = -508792;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    drum_mac_if #(.N(N), .M(M), .ACC_W(ACC_W)) bus ();
    drum_mac_pipe #(.K(K), .N(N), .M(M), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    typedef struct {
        int prod; int acc; int ovf;
        bit lit; int lprod; int lacc; int lovf;
        bit lat; int cyc;
    } exp_t;

    exp_t   q[$];
    int     n_vec = 0, n_err = 0, cyc = 0;
    longint m_acc = 0;
    int     m_ovf = 0;
    bit     lit_en = 0, chk_lat = 0;
    int     lit_prod = 0, lit_acc = 0, lit_ovf = -1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Approximate a magnitude: keep K-1 bits from the leading one, clear the rest,
    // then add half of the dropped range.
    function automatic int approx_mag(input int mag);
        int l = 0, s;
        if (mag == 0) return 0;
        while ((mag >> (l + 1)) != 0) l++;
        if (l <= K - 1) return mag;
        s = l - K + 1;
        return ((mag >> s) << s) | (1 << s);
    endfunction

    function automatic int model_prod(input int a, input int b, input bit ex);
        int ma = (a < 0) ? -a : a;
        int mb = (b < 0) ? -b : b;
        int p  = ex ? ma * mb : approx_mag(ma) * approx_mag(mb);
        return ((a < 0) != (b < 0)) ? -p : p;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        exp_t   e;
        longint t;
        int     p;
        if (rst) begin
            q.delete();
            m_acc = 0;
            m_ovf = 0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                p = model_prod(int'($signed(bus.in_a)), int'($signed(bus.in_b)), bus.in_exact);
                if (bus.in_clr) begin
                    m_acc = p;
                    m_ovf = 0;
                end else begin
                    t = m_acc + p;
                    if (t > AMAX || t < AMIN) begin
                        m_ovf = 1;
`ifdef DRUM_ACC_SAT_EN
                        t = (t > AMAX) ? AMAX : AMIN;
`else
                        t = (t > AMAX) ? t - 2 * (AMAX + 1) : t + 2 * (AMAX + 1);
`endif
                    end
                    m_acc = t;
                end
                e = '{p, int'(m_acc), m_ovf, lit_en, lit_prod, lit_acc, lit_ovf, chk_lat, cyc};
                q.push_back(e);
            end
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected out_valid", 1, 0);
                end else begin
                    e = q[0];
                    check("prod vs model", int'($signed(bus.out_prod)), e.prod);
                    check("acc vs model", int'($signed(bus.out_acc)), e.acc);
                    check("ovf vs model", bus.out_ovf, e.ovf);
                    if (bus.out_ready) begin
                        if (e.lit) begin
                            check("prod vs hand value", int'($signed(bus.out_prod)), e.lprod);
                            check("acc vs hand value", int'($signed(bus.out_acc)), e.lacc);
                            if (e.lovf >= 0) check("ovf vs hand value", bus.out_ovf, e.lovf);
                        end
                        if (e.lat) check("latency cycles", cyc - e.cyc, 3);
                        void'(q.pop_front());
                    end
                end
                if (!bus.out_ready) check("in_ready low while stalled", bus.in_ready, 0);
            end
        end
    end

    task automatic send(input int a, input int b, input bit ex, input bit cl,
                        input bit le, input int lp, input int la, input int lo);
        bit took;
        bus.in_a     = 8'(a);
        bus.in_b     = 8'(b);
        bus.in_exact = ex;
        bus.in_clr   = cl;
        bus.in_valid = 1'b1;
        lit_en = le; lit_prod = lp; lit_acc = la; lit_ovf = lo;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            if (took) return;
        end
        check("send timeout", 0, 1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        lit_en = 1'b0;
    endtask

    task automatic drain();
        for (int g = 0; g < 50 && q.size() > 0; g++) @(negedge clk);
        check("queue drained", q.size(), 0);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0;
        bus.in_exact = 0; bus.in_clr = 0; bus.out_ready = 1;

        // Pin the model against hand-computed products.
        check("model 100*3 approx", model_prod(100, 3, 0), 306);
        check("model -128*1 approx", model_prod(-128, 1, 0), -132);
        check("model 127*127 approx", model_prod(127, 127, 0), 15876);
        check("model 127*127 exact", model_prod(127, 127, 1), 16129);

        #2;
        check("reset out_valid", bus.out_valid, 0);
        check("reset in_ready", bus.in_ready, 1);
        check("reset out_prod", bus.out_prod, 0);
        check("reset out_acc", bus.out_acc, 0);
        check("reset out_ovf", bus.out_ovf, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;

        // Directed beats, sink always ready.
        chk_lat = 1;
        send(100,  3,   0, 1, 1, 306,    306,   0);
        send(100,  3,   1, 0, 1, 300,    606,   0);
        send(-100, 3,   0, 0, 1, -306,   300,   0);
        send(-128, 1,   0, 0, 1, -132,   168,   0);
        send(127,  127, 0, 0, 1, 15876,  16044, 0);
        send(127,  127, 1, 0, 1, 16129,  32173, 0);
        send(5,    -7,  0, 1, 1, -35,    -35,   0);
        send(5,    7,   0, 0, 1, 35,     0,     0);
        send(0,    -128,0, 0, 1, 0,      0,     0);
        send(0,    -128,1, 0, 1, 0,      0,     0);
        send(3,    4,   0, 1, 1, 12,     12,    0);
        idle();
        drain();

        // Back-pressure: sink stalls 5 cycles once results start arriving.
        chk_lat = 0;
        bus.out_ready = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(i * 20 + 1, -(i + 2) * 9, i[0], i == 0, 0, 0, 0, -1);
                idle();
            end
            begin
                for (int g = 0; g < 50 && !bus.out_valid; g++) begin @(posedge clk); #1; end
                check("out_valid under stall", bus.out_valid, 1);
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check("one result per cycle", bus.out_valid, 1);
                end
            end
        join
        drain();

        // Overflow: 127*127 approx repeated.
        chk_lat = 1;
        for (int i = 0; i < 34; i++) begin
            if (i == 32)      send(127, 127, 0, 0, 1, 15876, 523908, 0);
            else if (i == 33) send(127, 127, 0, 0, 1, 15876, OVF_ACC, 1);
            else              send(127, 127, 0, i == 0, 0, 0, 0, -1);
        end
        send(0, 0, 0, 0, 1, 0, OVF_ACC, 1);
        send(1, 1, 0, 1, 1, 1, 1, 0);
        idle();
        drain();

        // Reset with three beats in flight.
        chk_lat = 0;
        send(10, 10, 1, 1, 0, 0, 0, -1);
        send(20, 2, 0, 0, 0, 0, 0, -1);
        send(-3, 3, 0, 0, 0, 0, 0, -1);
        idle();
        rst = 1;
        #1;
        check("mid reset out_valid", bus.out_valid, 0);
        check("mid reset out_acc", bus.out_acc, 0);
        check("mid reset out_prod", bus.out_prod, 0);
        check("mid reset in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no stale out_valid", bus.out_valid, 0);
        end
        @(posedge clk); #1;
        chk_lat = 1;
        send(2, 3, 0, 0, 1, 6, 6, 0);
        send(-4, 5, 0, 0, 1, -20, -14, 0);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
